gsensor_spi_responder: RTL and testbench
========================================

Name: gsensor_spi_responder

Overview:
SPI slave that emulates the accelerometer at the far end of the 4-wire G-sensor SPI link. It answers register reads and writes from the system's SPI master using an ADXL345-style command byte. It serves a 64-byte register map, with acceleration data supplied from a local sample port. It is used as the bench/emulation counterpart of the G-sensor master and as a drop-in sensor model in FPGA loopback builds.

Parameters:
DEVID, 8'hE5, constant value returned at address 0x00.
SYNC_STAGES, 2, number of flops in each SCLK/SS_n/MOSI input synchronizer (min 2).

Ports:
clk_clk  input  1  system clock; SCLK frequency must be at most clk_clk/8.
reset_reset  input  1  asynchronous, active-high reset.
spi_sclk  input  1  SPI clock from master; mode 3 (CPOL=1, CPHA=1), idles high.
spi_ss_n  input  1  active-low chip select.
spi_mosi  input  1  master-out data, MSB first.
spi_miso  output  1  slave-out data, MSB first.
spi_miso_oe  output  1  output enable for the MISO pad driver.
sample_x  input  16  X acceleration, two's complement.
sample_y  input  16  Y acceleration, two's complement.
sample_z  input  16  Z acceleration, two's complement.
sample_valid  input  1  one-cycle strobe: capture sample_x/y/z.
wr_valid  output  1  one-cycle pulse per accepted register write.
wr_addr  output  6  address of the accepted write.
wr_data  output  8  data of the accepted write.
busy  output  1  high while a transaction is in progress (synchronized SS_n low).

Behaviour:
- Clocking and reset: one clock (clk_clk); reset is asynchronous, active-high (reset_reset).
- Reset values: spi_miso=0, spi_miso_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, FSM=IDLE, all register bytes=0x00.
- Input synchronization: SCLK, SS_n and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synchronized SCLK.
  - The rise event samples the synchronized MOSI.
  - The fall event updates MISO.
  - MISO changes within SYNC_STAGES+2 clk_clk cycles of the SCLK falling pin edge.
- FSM states:
  - IDLE: waiting for synchronized SS_n to fall. SS_n falling -> CMD, bit count=0, busy=1.
  - CMD: shift 8 MOSI bits on rise events. After the 8th bit, latch RW=bit7, MB=bit6, ADDR=bits5:0, then -> DATA.
  - DATA: 8-bit byte loop. After each 8th rise event, apply the address rule:
    - MB=1: address increments, wrapping 0x3F->0x00.
    - MB=0: address is held; further bytes access the same address.
- SS_n rising in any state -> IDLE within one cycle of the synchronized edge:
  - busy=0, spi_miso_oe=0, spi_miso=0.
  - A partial byte (fewer than 8 bits) is discarded: no write, no wr_valid.
- Read (RW=1):
  - On the first fall event in DATA, the read byte for ADDR is loaded into the shift register and bit7 is driven. Each later fall event shifts out the next bit.
  - The read byte for the next address is fetched at the 8th rise event.
  - spi_miso_oe=1 from entry to DATA until SS_n rises.
  - During CMD, spi_miso_oe=0 and spi_miso=0.
- Write (RW=1 is read, RW=0 is write):
  - At the 8th rise event of each data byte, if ADDR is writable: store the byte and pulse wr_valid for exactly one cycle with wr_addr/wr_data.
  - spi_miso_oe stays 0 for the whole write transaction.
- Register map:
  - 0x00 reads DEVID.
  - 0x32..0x37 are data registers, little-endian: X_L, X_H, Y_L, Y_H, Z_L, Z_H.
  - 0x00, 0x30 and 0x32..0x37 are read-only. Writes to them are dropped with no wr_valid pulse.
  - All other addresses are read/write, 8-bit.
- Sample capture:
  - sample_valid with busy=0: copy sample_x/y/z into 0x32..0x37 on that edge.
  - sample_valid with busy=1: hold a pending copy and apply it on the cycle busy falls, so a multi-byte read returns one coherent sample.
  - A second sample_valid while pending overwrites the pending copy.
  - Simultaneous sample_valid and SS_n falling: the capture wins and completes before the first read fetch.
- Reset mid-transaction: all state returns to reset values. The next transaction requires a fresh SS_n falling edge; if SS_n is still low when reset releases, the block stays IDLE until SS_n goes high then low again.

Test Plan:
- Read DEVID: cmd 0x80, then one dummy byte -> MISO returns 0xE5; spi_miso_oe=1 only during the data byte; no wr_valid.
- Write then read: cmd 0x2D + data 0x08 -> one wr_valid pulse, wr_addr=0x2D, wr_data=0x08; then cmd 0xAD read -> 0x08.
- Burst read: sample X=0x1234, Y=0xFF80, Z=0x0100 with busy=0; cmd 0xF2 plus 6 bytes -> 0x34,0x12,0x80,0xFF,0x00,0x01.
- Coherency: during that burst, pulse sample_valid with X=0xAAAA after byte 2 -> remaining bytes are unchanged; the next burst returns 0xAA,0xAA at 0x32/0x33.
- Abort and wrap:
  - cmd 0x7F + 0x11 + 0x22, raise SS_n after 4 bits of the third byte -> wr_valid at 0x3F=0x11 and at 0x00 dropped (read-only); no third pulse.
  - Write 0x2C=0x0A, then SS_n up after 5 bits -> no pulse; 0x2C reads back 0x0A.
- Reset mid-read: assert reset_reset during the second data bit -> spi_miso_oe=0 and busy=0 immediately; registers read 0x00 afterward except 0x00=0xE5.

Source files
------------

// File: rtl/gsensor_spi_responder.sv
// ADXL345-style SPI mode-3 register slave: 64-byte map, DEVID at 0x00 and X/Y/Z sample
// registers at 0x32..0x37. Samples that arrive mid-transaction are deferred so bursts stay coherent.
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        spi_sclk,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        wr_valid,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_prev, ss_prev;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_rise   = ss_s & ~ss_prev;
    assign ss_fall   = ~ss_s & ss_prev;

    // SS_n chain resets low: a select still held low when reset releases is not a new falling edge
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sclk_sync <= '1;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
            ss_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    logic [7:0]  regs [64];
    logic [2:0]  bit_cnt;
    logic [6:0]  rx;
    logic [6:0]  tx;
    logic [7:0]  rx_byte, rd_buf, fetch_data;
    logic [5:0]  addr, fetch_addr;
    logic        rw, mb, byte_done;
    logic        pend, busy_drop, cap_now, cap_en;
    logic [15:0] pend_x, pend_y, pend_z, cap_x, cap_y, cap_z;

    function automatic logic writable(input logic [5:0] a);
        return !((a == 6'h00) || (a == 6'h30) || ((a >= 6'h32) && (a <= 6'h37)));
    endfunction

    assign rx_byte    = {rx, mosi_s};
    assign fetch_addr = (state == CMD) ? rx_byte[5:0] : (mb ? addr + 6'd1 : addr);
    assign fetch_data = (fetch_addr == 6'd0) ? DEVID : regs[fetch_addr];

    assign busy_drop = busy && (next_state == IDLE);
    assign cap_now   = sample_valid && (!busy || busy_drop);
    assign cap_en    = cap_now || (pend && busy_drop);
    assign cap_x     = cap_now ? sample_x : pend_x;
    assign cap_y     = cap_now ? sample_y : pend_y;
    assign cap_z     = cap_now ? sample_z : pend_z;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= IDLE;
        else             state <= next_state;
    end

    always_comb begin
        next_state = state;
        byte_done  = 1'b0;
        case (state)
            IDLE: if (ss_fall) next_state = CMD;
            CMD: begin
                if (ss_rise) next_state = IDLE;
                else if (sclk_rise && (bit_cnt == 3'd7)) begin
                    byte_done  = 1'b1;
                    next_state = DATA;
                end
            end
            DATA: begin
                if (ss_rise) next_state = IDLE;
                else if (sclk_rise && (bit_cnt == 3'd7)) byte_done = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            rd_buf      <= '0;
            addr        <= '0;
            rw          <= 1'b0;
            mb          <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            pend        <= 1'b0;
            pend_x      <= '0;
            pend_y      <= '0;
            pend_z      <= '0;
        end else begin
            wr_valid <= 1'b0;
            busy     <= (next_state != IDLE);

            if (state == IDLE && next_state == CMD) begin
                bit_cnt <= '0;
            end else if (state != IDLE && sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx      <= rx_byte[6:0];
            end

            if (next_state == IDLE) begin
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
            end else if (state == CMD && byte_done) begin
                rw          <= rx_byte[7];
                mb          <= rx_byte[6];
                addr        <= rx_byte[5:0];
                rd_buf      <= fetch_data;
                spi_miso_oe <= rx_byte[7];
            end else if (state == DATA) begin
                if (byte_done) begin
                    if (!rw && writable(addr)) begin
                        regs[addr] <= rx_byte;
                        wr_valid   <= 1'b1;
                        wr_addr    <= addr;
                        wr_data    <= rx_byte;
                    end
                    addr   <= fetch_addr;
                    rd_buf <= fetch_data;
                end else if (sclk_fall && rw) begin
                    if (bit_cnt == 3'd0) begin
                        tx       <= rd_buf[6:0];
                        spi_miso <= rd_buf[7];
                    end else begin
                        tx       <= {tx[5:0], 1'b0};
                        spi_miso <= tx[6];
                    end
                end
            end

            // Samples seen while busy wait here until the transaction ends
            if (cap_en) begin
                regs[6'h32] <= cap_x[7:0];
                regs[6'h33] <= cap_x[15:8];
                regs[6'h34] <= cap_y[7:0];
                regs[6'h35] <= cap_y[15:8];
                regs[6'h36] <= cap_z[7:0];
                regs[6'h37] <= cap_z[15:8];
            end
            if (busy_drop) pend <= 1'b0;
            if (sample_valid && busy && !busy_drop) begin
                pend   <= 1'b1;
                pend_x <= sample_x;
                pend_y <= sample_y;
                pend_z <= sample_z;
            end
        end
    end

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Scoreboard bench for gsensor_spi_responder: an SPI master drives transactions, a register-map
// model queues expected read bytes and write pulses, and pin-level monitors pop and compare.
module tb_gsensor_spi_responder;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst, sclk, ss_n, mosi, sv;
    logic        miso, oe, wv, busy;
    logic [15:0] sx, sy, sz;
    logic [5:0]  wa;
    logic [7:0]  wd;

    always #5 clk = ~clk;

    gsensor_spi_responder dut (
        .clk_clk(clk), .reset_reset(rst),
        .spi_sclk(sclk), .spi_ss_n(ss_n), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(oe),
        .sample_x(sx), .sample_y(sy), .sample_z(sz), .sample_valid(sv),
        .wr_valid(wv), .wr_addr(wa), .wr_data(wd), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mreg [64];
    logic [15:0] mp_x, mp_y, mp_z;
    bit          mpend = 0;
    bit          in_txn = 0;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  tx_data [16];
    logic [15:0] nx, ny, nz;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ro(input logic [5:0] a);
        return (a == 6'h00) || (a == 6'h30) || (a inside {[6'h32:6'h37]});
    endfunction

    function automatic logic [7:0] model_rd(input logic [5:0] a);
        return (a == 6'h00) ? 8'hE5 : mreg[a];
    endfunction

    task automatic model_load(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        mreg[6'h32] = x[7:0];  mreg[6'h33] = x[15:8];
        mreg[6'h34] = y[7:0];  mreg[6'h35] = y[15:8];
        mreg[6'h36] = z[7:0];  mreg[6'h37] = z[15:8];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
        mpend = 0;
    endtask

    // Write-pulse monitor
    logic [15:0] wr_e;
    always @(negedge clk) begin
        if (wv) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", wa, wd);
            end else begin
                wr_e = exp_wr.pop_front();
                chk("wr_pulse", {2'b00, wa, wd}, wr_e);
            end
        end
    end

    // Read-byte monitor: the master's view of MISO while the slave drives it
    int         mon_cnt = 0;
    logic [7:0] mon_sh = 8'h00;
    always @(posedge sclk or posedge ss_n or posedge rst) begin
        if (rst || ss_n) begin
            mon_cnt = 0;
        end else if (oe) begin
            mon_sh = {mon_sh[6:0], miso};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got 0x%0h, expected no read byte", mon_sh);
                end else begin
                    chk("rd_byte", {8'h00, mon_sh}, {8'h00, exp_rd.pop_front()});
                end
            end
        end
    end

    task automatic half_wait();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, input bit do_chk, input logic exp_oe);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = b[7-i];
            half_wait();
            if (i == 0 && do_chk) begin
                chk("oe_in_byte", {15'd0, oe}, {15'd0, exp_oe});
                chk("busy_in_txn", {15'd0, busy}, 16'd1);
            end
            sclk = 1'b1;
            half_wait();
        end
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(posedge clk); #1;
        sx = x; sy = y; sz = z; sv = 1'b1;
        @(posedge clk); #1;
        sv = 1'b0;
        if (in_txn) begin
            mpend = 1; mp_x = x; mp_y = y; mp_z = z;
        end else begin
            model_load(x, y, z);
        end
    endtask

    task automatic txn(input logic [7:0] cmd, input int nbytes, input int tail, input int pulse_after);
        logic [5:0] a;
        a = cmd[5:0];
        for (int k = 0; k < nbytes; k++) begin
            if (cmd[7]) begin
                exp_rd.push_back(model_rd(a));
            end else if (!model_ro(a)) begin
                exp_wr.push_back({2'b00, a, tx_data[k]});
                mreg[a] = tx_data[k];
            end
            if (cmd[6]) a = a + 6'd1;
        end
        in_txn = 1;
        ss_n = 1'b0;
        half_wait();
        send_byte(cmd, 8, 1, 1'b0);
        for (int k = 0; k < nbytes; k++) begin
            send_byte(cmd[7] ? 8'hFF : tx_data[k], 8, 1, cmd[7]);
            if (k == pulse_after) pulse_sample(nx, ny, nz);
        end
        if (tail > 0) send_byte(tx_data[nbytes], tail, 1, cmd[7]);
        half_wait();
        ss_n = 1'b1;
        in_txn = 0;
        if (mpend) begin
            model_load(mp_x, mp_y, mp_z);
            mpend = 0;
        end
        repeat (4) half_wait();
        chk("busy_after", {15'd0, busy}, 16'd0);
        chk("oe_after", {15'd0, oe}, 16'd0);
        chk("miso_after", {15'd0, miso}, 16'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  cmd;
        int          nb, tail, pa;

        rst = 1'b1; sclk = 1'b1; ss_n = 1'b1; mosi = 1'b0;
        sv = 1'b0; sx = '0; sy = '0; sz = '0;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_miso", {15'd0, miso}, 16'd0);
        chk("rst_oe", {15'd0, oe}, 16'd0);
        chk("rst_wr_valid", {15'd0, wv}, 16'd0);
        chk("rst_wr_addr", {10'd0, wa}, 16'd0);
        chk("rst_wr_data", {8'd0, wd}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        txn(8'h80, 1, 0, -1);

        tx_data[0] = 8'h08;
        txn(8'h2D, 1, 0, -1);
        txn(8'hAD, 1, 0, -1);

        pulse_sample(16'h1234, 16'hFF80, 16'h0100);
        nx = 16'hAAAA; ny = 16'hFF80; nz = 16'h0100;
        txn(8'hF2, 6, 0, 1);
        txn(8'hF2, 6, 0, -1);

        tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h22;
        txn(8'h7F, 2, 4, -1);

        tx_data[0] = 8'h0A;
        txn(8'h2C, 1, 0, -1);
        tx_data[0] = 8'h55;
        txn(8'h2C, 0, 5, -1);
        txn(8'hAC, 1, 0, -1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom; cmd = r[7:0];
            nb = $urandom_range(1, 4);
            for (int k = 0; k < 6; k++) begin
                r = $urandom; tx_data[k] = r[7:0];
            end
            tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            pa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
            r = $urandom; nx = r[15:0]; ny = r[31:16];
            r = $urandom; nz = r[15:0];
            if ($urandom_range(0, 2) == 0) pulse_sample(r[31:16], nx, ny);
            txn(cmd, nb, tail, pa);
        end

        // Reset in the middle of a read, with SS_n still low afterwards
        pulse_sample(16'h5A5A, 16'hC3C3, 16'h7E7E);
        ss_n = 1'b0;
        half_wait();
        send_byte(8'h80, 8, 0, 1'b0);
        sclk = 1'b0; half_wait(); sclk = 1'b1; half_wait();
        sclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_oe", {15'd0, oe}, 16'd0);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_miso", {15'd0, miso}, 16'd0);
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        sclk = 1'b1;
        half_wait();
        send_byte(8'h2D, 8, 0, 1'b0);
        send_byte(8'h55, 8, 0, 1'b0);
        chk("held_ss_busy", {15'd0, busy}, 16'd0);
        ss_n = 1'b1;
        repeat (4) half_wait();

        txn(8'hC0, 3, 0, -1);
        txn(8'hF2, 6, 0, -1);
        txn(8'hAD, 1, 0, -1);
        txn(8'hBF, 1, 0, -1);

        repeat (10) @(posedge clk);
        #1;
        chk("rd_queue_drained", exp_rd.size()[15:0], 16'd0);
        chk("wr_queue_drained", exp_wr.size()[15:0], 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
